// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op codes, FSM state encoding and op-class helpers.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;
    localparam logic [3:0] MDU_MADD  = 4'd9;
    localparam logic [3:0] MDU_MADDU = 4'd10;
    localparam logic [3:0] MDU_MSUB  = 4'd11;
    localparam logic [3:0] MDU_MSUBU = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } mdu_state_e;

    function automatic logic is_mul(input logic [3:0] op);
        return op inside {MDU_MULT, MDU_MULTU, MDU_MADD,
                          MDU_MADDU, MDU_MSUB, MDU_MSUBU};
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return op inside {MDU_DIV, MDU_DIVU};
    endfunction

    function automatic logic is_smul(input logic [3:0] op);
        return op inside {MDU_MULT, MDU_MADD, MDU_MSUB};
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Unsigned restoring divider, one quotient bit per step_en cycle.
// Ports: clk, reset (async, active-low), load/dividend/divisor, step_en, quotient, remainder.
module mdu_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             step_en,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] rem_r, quo_r, dvs_r;
    logic [WIDTH:0]   shifted, diff;

    // Dividend bits shift out of the quotient register into the remainder.
    assign shifted = {rem_r, quo_r[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_r};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_r <= '0;
            quo_r <= '0;
            dvs_r <= '0;
        end else if (load) begin
            rem_r <= '0;
            quo_r <= dividend;
            dvs_r <= divisor;
        end else if (step_en) begin
            if (!diff[WIDTH]) begin
                rem_r <= diff[WIDTH-1:0];
                quo_r <= {quo_r[WIDTH-2:0], 1'b1};
            end else begin
                rem_r <= shifted[WIDTH-1:0];
                quo_r <= {quo_r[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_r;
    assign remainder = rem_r;

endmodule

// File: rtl/mdu_iter.sv
// E-stage multiply/divide unit owning HI/LO; multi-cycle mult/mac and iterative divide.
// Ports: clk, reset (async, active-low), op_a, op_b, mdu_op, req in; start, busy, done, dataout out.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       mdu_op,
    input  logic             req,
    output logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dataout
);

    localparam int CMAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    mdu_state_e state, state_n;

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   hi, lo, a_raw;
    logic [2*WIDTH-1:0] prod, prod_n, ext_a, ext_b;
    logic [3:0]         op_r;
    logic               neg_q, neg_r, div_zero, div_ovf;
    logic               sdiv, last, div_load;
    logic [WIDTH-1:0]   abs_a, abs_b, quo, rem;

    assign start = !req && (is_mul(mdu_op) || is_div(mdu_op));
    assign last  = (cnt == CW'(1));

    assign ext_a  = is_smul(mdu_op) ? {{WIDTH{op_a[WIDTH-1]}}, op_a}
                                    : {{WIDTH{1'b0}}, op_a};
    assign ext_b  = is_smul(mdu_op) ? {{WIDTH{op_b[WIDTH-1]}}, op_b}
                                    : {{WIDTH{1'b0}}, op_b};
    assign prod_n = ext_a * ext_b;

    assign sdiv  = (mdu_op == MDU_DIV);
    assign abs_a = (sdiv && op_a[WIDTH-1]) ? -op_a : op_a;
    assign abs_b = (sdiv && op_b[WIDTH-1]) ? -op_b : op_b;

    assign div_load = (state == ST_IDLE) && start && is_div(mdu_op);

    mdu_div_core #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (div_load),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .step_en   (state == ST_DIV),
        .quotient  (quo),
        .remainder (rem)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: if (start) state_n = is_mul(mdu_op) ? ST_MUL : ST_DIV;
            ST_MUL:  if (last)  state_n = ST_IDLE;
            ST_DIV:  if (last)  state_n = ST_FIX;
            ST_FIX:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            prod     <= '0;
            op_r     <= MDU_NONE;
            a_raw    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        op_r <= mdu_op;
                        if (is_mul(mdu_op)) begin
                            prod <= prod_n;
                            cnt  <= CW'(MUL_LAT);
                        end else begin
                            cnt      <= CW'(WIDTH);
                            a_raw    <= op_a;
                            neg_q    <= sdiv && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                            neg_r    <= sdiv && op_a[WIDTH-1];
                            div_zero <= (op_b == '0);
                            div_ovf  <= sdiv && (op_a == MIN_VAL) && (op_b == '1);
                        end
                    end else if (!req && mdu_op == MDU_MTHI) begin
                        hi <= op_a;
                    end else if (!req && mdu_op == MDU_MTLO) begin
                        lo <= op_a;
                    end
                end
                ST_MUL: begin
                    cnt <= cnt - CW'(1);
                    if (last) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        unique case (1'b1)
                            (op_r == MDU_MADD || op_r == MDU_MADDU):
                                {hi, lo} <= {hi, lo} + prod;
                            (op_r == MDU_MSUB || op_r == MDU_MSUBU):
                                {hi, lo} <= {hi, lo} - prod;
                            default:
                                {hi, lo} <= prod;
                        endcase
                    end
                end
                ST_DIV: cnt <= cnt - CW'(1);
                ST_FIX: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    unique case (1'b1)
                        div_zero: begin
                            lo <= '1;
                            hi <= a_raw;
                        end
                        div_ovf: begin
                            lo <= MIN_VAL;
                            hi <= '0;
                        end
                        default: begin
                            lo <= neg_q ? -quo : quo;
                            hi <= neg_r ? -rem : rem;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        dataout = '0;
        unique case (1'b1)
            (mdu_op == MDU_MFHI): dataout = hi;
            (mdu_op == MDU_MFLO): dataout = lo;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: directed cases plus random ops against
// an arithmetic model of HI/LO; a monitor checks reads and busy latency.
module tb_mdu_iter;
    import mdu_pkg::*;

    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] op_a = '0, op_b = '0;
    logic [3:0]  mdu_op = MDU_NONE;
    logic        req = 1'b0;
    logic        start, busy, done;
    logic [31:0] dataout;

    int checks = 0;
    int failures = 0;

    logic [31:0] mhi = '0, mlo = '0;
    logic [31:0] exp_q[$];
    int          lat_q[$];

    mdu_iter #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
        .clk     (clk),
        .reset   (reset),
        .op_a    (op_a),
        .op_b    (op_b),
        .mdu_op  (mdu_op),
        .req     (req),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .dataout (dataout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural view of HI/LO: plain arithmetic on the architectural rules.
    task automatic model(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int lat);
        logic [63:0] acc, p;
        longint      sa, sb;
        int          da, db;
        lat = 0;
        acc = {mhi, mlo};
        sa = $signed(a);
        sb = $signed(b);
        if (op inside {MDU_MULT, MDU_MADD, MDU_MSUB}) p = sa * sb;
        else p = {32'b0, a} * {32'b0, b};
        if (op inside {MDU_MULT, MDU_MULTU}) begin
            {mhi, mlo} = p;
            lat = MUL_LAT;
        end else if (op inside {MDU_MADD, MDU_MADDU}) begin
            {mhi, mlo} = acc + p;
            lat = MUL_LAT;
        end else if (op inside {MDU_MSUB, MDU_MSUBU}) begin
            {mhi, mlo} = acc - p;
            lat = MUL_LAT;
        end else if (op inside {MDU_DIV, MDU_DIVU}) begin
            lat = WIDTH + 1;
            if (b == 0) begin
                mlo = 32'hFFFF_FFFF;
                mhi = a;
            end else if (op == MDU_DIV && a == 32'h8000_0000 &&
                         b == 32'hFFFF_FFFF) begin
                mlo = 32'h8000_0000;
                mhi = 0;
            end else if (op == MDU_DIV) begin
                da = $signed(a);
                db = $signed(b);
                mlo = da / db;
                mhi = da % db;
            end else begin
                mlo = a / b;
                mhi = a % b;
            end
        end else if (op == MDU_MTHI) begin
            mhi = a;
        end else if (op == MDU_MTLO) begin
            mlo = a;
        end
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (done) return;
        end
        checks++;
        failures++;
        $display("FAIL done_timeout: got no done expected done within %0d",
                 budget);
    endtask

    // Called at posedge+1 with the unit idle.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        int lat;
        model(op, a, b, lat);
        if (lat > 0) lat_q.push_back(lat);
        mdu_op = op;
        op_a = a;
        op_b = b;
        @(posedge clk);
        #1;
        mdu_op = MDU_NONE;
        if (lat > 0) wait_done(lat + 5);
    endtask

    task automatic read_hilo();
        exp_q.push_back(mhi);
        mdu_op = MDU_MFHI;
        @(posedge clk);
        #1;
        exp_q.push_back(mlo);
        mdu_op = MDU_MFLO;
        @(posedge clk);
        #1;
        mdu_op = MDU_NONE;
    endtask

    // Monitor: compares reads and measures busy length per completed op.
    int bcnt = 0;
    logic pdone = 1'b0;
    always @(negedge clk) begin
        logic [31:0] e;
        int l;
        if (!reset) begin
            bcnt = 0;
            pdone = 1'b0;
        end else begin
            if ((mdu_op == MDU_MFHI || mdu_op == MDU_MFLO) &&
                exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(mdu_op == MDU_MFHI ? "mfhi" : "mflo", dataout, e);
            end
            if (busy) bcnt++;
            if (done) begin
                if (lat_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_unexpected: got done expected none");
                end else begin
                    l = lat_q.pop_front();
                    chk("busy_cycles", 32'(bcnt), 32'(l));
                end
                chk("done_single", {31'b0, pdone}, 32'd0);
                bcnt = 0;
            end
            pdone = done;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    logic [3:0] rops [10] = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU,
                             MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU,
                             MDU_MTHI, MDU_MTLO};

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        int          lat;

        mdu_op = MDU_MFHI;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_hi", dataout, 32'd0);
        mdu_op = MDU_MFLO;
        #1;
        chk("rst_lo", dataout, 32'd0);
        mdu_op = MDU_NONE;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        do_op(MDU_MULT, 32'hFFFF_FFFF, 32'd2);
        read_hilo();

        // Ops presented while busy must be ignored.
        model(MDU_DIVU, 32'd100, 32'd7, lat);
        lat_q.push_back(lat);
        mdu_op = MDU_DIVU;
        op_a = 32'd100;
        op_b = 32'd7;
        @(posedge clk);
        #1;
        mdu_op = MDU_MTHI;
        op_a = 32'hDEAD_BEEF;
        wait_done(lat + 5);
        mdu_op = MDU_NONE;
        read_hilo();

        do_op(MDU_DIV, -32'sd7, 32'd2);
        read_hilo();
        do_op(MDU_DIV, 32'd5, 32'd0);
        read_hilo();
        do_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        read_hilo();

        do_op(MDU_MTLO, 32'd10, 32'd0);
        do_op(MDU_MTHI, 32'd0, 32'd0);
        do_op(MDU_MADD, 32'd3, 32'd4);
        read_hilo();
        do_op(MDU_MSUBU, 32'd5, 32'd5);
        read_hilo();

        req = 1'b1;
        mdu_op = MDU_MULT;
        op_a = 32'd7;
        op_b = 32'd9;
        #1;
        chk("req_start", {31'b0, start}, 32'd0);
        @(posedge clk);
        #1;
        chk("req_busy", {31'b0, busy}, 32'd0);
        mdu_op = MDU_MTLO;
        @(posedge clk);
        #1;
        req = 1'b0;
        mdu_op = MDU_NONE;
        read_hilo();

        model(MDU_DIVU, 32'd9, 32'd2, lat);
        lat_q.push_back(lat);
        mdu_op = MDU_DIVU;
        op_a = 32'd9;
        op_b = 32'd2;
        @(posedge clk);
        #1;
        req = 1'b1;
        mdu_op = MDU_MULT;
        wait_done(lat + 5);
        req = 1'b0;
        mdu_op = MDU_NONE;
        read_hilo();

        mdu_op = MDU_DIV;
        op_a = 32'd1000;
        op_b = 32'd3;
        @(posedge clk);
        #1;
        mdu_op = MDU_NONE;
        repeat (9) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        mdu_op = MDU_MFHI;
        #1;
        chk("arst_hi", dataout, 32'd0);
        mdu_op = MDU_MFLO;
        #1;
        chk("arst_lo", dataout, 32'd0);
        mdu_op = MDU_NONE;
        mhi = '0;
        mlo = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        do_op(MDU_MULTU, 32'd3, 32'd3);
        read_hilo();

        for (int i = 0; i < 60; i++) begin
            op = rops[$urandom_range(0, 9)];
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 20);
            if ($urandom_range(0, 7) == 0) b = 0;
            if (op == MDU_DIV && $urandom_range(0, 7) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            do_op(op, a, b);
            if ($urandom_range(0, 1) == 0) read_hilo();
        end
        read_hilo();

        repeat (3) @(posedge clk);
        #1;
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("lat_q_drained", 32'(lat_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised multiply/divide unit for the E stage. Successor to the fixed 32-bit MDU.
- Adds generic WIDTH, configurable multiply latency, a true iterative restoring divider with defined divide-by-zero/overflow results, multiply-accumulate ops (madd/maddu/msub/msubu), and a done pulse.
- Owns HI/LO. Reads HI/LO for mfhi/mflo combinationally.

Parameters:
- WIDTH, 32, operand/HI/LO width (≥4, even).
- MUL_LAT, 5, cycles busy for mult-class ops (≥1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- op_a  in  WIDTH  rs operand.
- op_b  in  WIDTH  rt operand.
- mdu_op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu, 11 msub, 12 msubu; 13-15 treated as none.
- req  in  1  exception/interrupt flush of the current E instruction.
- start  out  1  combinational; = !req & mdu_op in {1,2,3,4,9..12}.
- busy  out  1  registered; high while an op is in flight.
- done  out  1  registered; one-cycle pulse on the cycle after HI/LO update.
- dataout  out  WIDTH  combinational; HI on mfhi, LO on mflo, else 0.

Behaviour:
- Reset (reset=0, async): HI=LO=0, busy=0, done=0, state IDLE, counter=0, divider regs 0. Reset mid-operation aborts; HI/LO read 0 immediately.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE: start accepted at edge t:
  - mult-class ops: latch product (signed for 1/9/11, unsigned for 2/10/12, 2*WIDTH bits); counter=MUL_LAT; go to MUL.
  - div/divu: latch |operands| (or raw for divu), sign flags; counter=WIDTH; go to DIV.
- MUL: counter decrements each edge. At the edge where counter reaches 1:
  - {HI,LO} ← product (mult/multu), {HI,LO}+product (madd*), or {HI,LO}−product (msub*), mod 2^(2*WIDTH).
  - busy falls and done=1 on the same edge. busy is high exactly MUL_LAT cycles.
- DIV: one restoring shift-subtract step per edge, WIDTH steps, then FIX.
- FIX (1 cycle): apply signs; quotient negated if signs differ; remainder takes dividend sign. Writes LO=quotient, HI=remainder, busy→0, done=1. Total busy = WIDTH+1 cycles.
- Divide by zero: same latency; LO=all ones, HI=op_a (dividend, unmodified).
- Signed overflow (min / −1): LO=min, HI=0.
- mthi/mtlo in IDLE with req=0: HI or LO ← op_a at that edge. No busy.
- req=1 blocks issue of all ops and mthi/mtlo that cycle. It does NOT affect an in-flight op, which belongs to an older committed instruction and must complete.
- Any op presented while busy=1 is ignored. The pipeline stalls mult/div/mf/mt while busy|start.
- done and a new start may coincide: the new op is accepted only from IDLE, i.e. the cycle after busy falls.

Decomposition:
- mdu_pkg: op code localparams (MDU_NONE..MDU_MSUBU), state encoding, is_mul/is_div helper functions.
- Sub-module mdu_div_core: unsigned restoring divider, WIDTH-parameterised.
  - Ports: clk, reset, load, dividend, divisor, step_en, quotient, remainder.
  - Sign handling and the divide-by-zero/overflow overrides stay in mdu_iter.

Test Plan:
- mult op_a=0xFFFFFFFF, op_b=2 → busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE; done pulses once; mfhi dataout=0xFFFFFFFF.
- divu 100/7 → busy 33 cycles; LO=14, HI=2. div −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div 5/0 → LO=0xFFFFFFFF, HI=5. div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- mtlo 10, mthi 0, madd 3*4 → LO=22, HI=0; then msubu 5*5 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- req=1 with mdu_op=mult → start=0, busy stays 0, HI/LO unchanged. Raise req during an in-flight divu 9/2 → result still LO=4, HI=1 on schedule.
- reset driven low asynchronously 10 cycles into a div → busy=0, HI=LO=0 before next clk edge; after release, a new multu 3*3 gives LO=9.
